// File: rtl/axi_ddc_oct_prog_master.sv
// AXI4-Lite master that expands high-level DDC octet commands (program, rate, resync, readback)
// into ordered single-beat register transactions and returns one response per command.
module axi_ddc_oct_prog_master #(
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int C_M_AXI_ADDR_WIDTH = 5
) (
    input  logic                          M_AXI_ACLK,
    input  logic                          M_AXI_ARESETN,

    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [1:0]                    cmd_op,
    input  logic [C_M_AXI_DATA_WIDTH-1:0] cmd_ch,
    input  logic [C_M_AXI_DATA_WIDTH-1:0] cmd_pinc,
    input  logic [C_M_AXI_DATA_WIDTH-1:0] cmd_poff,
    output logic                          rsp_valid,
    output logic [C_M_AXI_DATA_WIDTH-1:0] rsp_data,
    output logic                          rsp_err,
    output logic                          busy,

    output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_AWADDR,
    output logic [2:0]                    M_AXI_AWPROT,
    output logic                          M_AXI_AWVALID,
    input  logic                          M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0] M_AXI_WDATA,
    output logic [3:0]                    M_AXI_WSTRB,
    output logic                          M_AXI_WVALID,
    input  logic                          M_AXI_WREADY,
    input  logic [1:0]                    M_AXI_BRESP,
    input  logic                          M_AXI_BVALID,
    output logic                          M_AXI_BREADY,
    output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_ARADDR,
    output logic [2:0]                    M_AXI_ARPROT,
    output logic                          M_AXI_ARVALID,
    input  logic                          M_AXI_ARREADY,
    input  logic [C_M_AXI_DATA_WIDTH-1:0] M_AXI_RDATA,
    input  logic [1:0]                    M_AXI_RRESP,
    input  logic                          M_AXI_RVALID,
    output logic                          M_AXI_RREADY
);

    localparam int DW = C_M_AXI_DATA_WIDTH;
    localparam int AW = C_M_AXI_ADDR_WIDTH;

    localparam logic [1:0] OpProg   = 2'd0;
    localparam logic [1:0] OpRate   = 2'd1;
    localparam logic [1:0] OpResync = 2'd2;
    localparam logic [1:0] OpRead   = 2'd3;

    typedef enum logic [2:0] {
        StIdle,
        StWrReq,
        StWrResp,
        StRdReq,
        StRdResp,
        StDone
    } state_e;

    state_e          state_q, state_d;
    logic [1:0]      op_q;
    logic [DW-1:0]   ch_q, pinc_q, poff_q;
    logic [1:0]      step_q;
    logic            aw_done_q, w_done_q;
    logic            err_q;
    logic [DW-1:0]   rdata_q;
    logic            cmd_ready_q;

    logic [AW-1:0]   step_addr;
    logic [DW-1:0]   step_data;
    logic            last_step;
    logic            cmd_hs, aw_hs, w_hs;

    assign cmd_hs = cmd_valid & cmd_ready_q & (state_q == StIdle);
    assign aw_hs  = M_AXI_AWVALID & M_AXI_AWREADY;
    assign w_hs   = M_AXI_WVALID & M_AXI_WREADY;

    // Channel register goes last so the slave publishes a consistent pinc/poff/ch set.
    always_comb begin
        step_addr = '0;
        step_data = '0;
        last_step = 1'b1;
        unique case (op_q)
            OpProg: begin
                last_step = (step_q == 2'd2);
                case (step_q)
                    2'd0:    begin step_addr = AW'(5'h04); step_data = pinc_q; end
                    2'd1:    begin step_addr = AW'(5'h08); step_data = poff_q; end
                    default: begin step_addr = AW'(5'h00); step_data = ch_q;   end
                endcase
            end
            OpRate:   begin step_addr = AW'(5'h0C); step_data = poff_q; end
            OpResync: begin step_addr = AW'(5'h10); step_data = DW'(1); end
            OpRead:   ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (cmd_hs) state_d = (cmd_op == OpRead) ? StRdReq : StWrReq;
            StWrReq:  if (aw_done_q && w_done_q) state_d = StWrResp;
            StWrResp: if (M_AXI_BVALID) state_d = last_step ? StDone : StWrReq;
            StRdReq:  if (M_AXI_ARREADY) state_d = StRdResp;
            StRdResp: if (M_AXI_RVALID) state_d = StDone;
            StDone:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            state_q     <= StIdle;
            cmd_ready_q <= 1'b0;
            op_q        <= '0;
            ch_q        <= '0;
            pinc_q      <= '0;
            poff_q      <= '0;
            step_q      <= '0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            err_q       <= 1'b0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= (state_d == StIdle);
            case (state_q)
                StIdle: begin
                    if (cmd_hs) begin
                        op_q      <= cmd_op;
                        ch_q      <= cmd_ch;
                        pinc_q    <= cmd_pinc;
                        poff_q    <= cmd_poff;
                        step_q    <= '0;
                        aw_done_q <= 1'b0;
                        w_done_q  <= 1'b0;
                        err_q     <= 1'b0;
                        rdata_q   <= '0;
                    end
                end
                StWrReq: begin
                    if (aw_hs) aw_done_q <= 1'b1;
                    if (w_hs)  w_done_q  <= 1'b1;
                end
                StWrResp: begin
                    if (M_AXI_BVALID) begin
                        err_q     <= err_q | (M_AXI_BRESP != 2'b00);
                        step_q    <= step_q + 2'd1;
                        aw_done_q <= 1'b0;
                        w_done_q  <= 1'b0;
                    end
                end
                StRdResp: begin
                    if (M_AXI_RVALID) begin
                        rdata_q <= M_AXI_RDATA;
                        err_q   <= err_q | (M_AXI_RRESP != 2'b00);
                    end
                end
                default: ;
            endcase
        end
    end

    assign cmd_ready     = cmd_ready_q;
    assign busy          = (state_q != StIdle);

    assign M_AXI_AWVALID = (state_q == StWrReq) & ~aw_done_q;
    assign M_AXI_WVALID  = (state_q == StWrReq) & ~w_done_q;
    assign M_AXI_AWADDR  = (state_q == StWrReq) ? step_addr : '0;
    assign M_AXI_WDATA   = (state_q == StWrReq) ? step_data : '0;
    assign M_AXI_AWPROT  = 3'b000;
    assign M_AXI_WSTRB   = 4'hF;
    assign M_AXI_BREADY  = (state_q == StWrResp);

    assign M_AXI_ARVALID = (state_q == StRdReq);
    assign M_AXI_ARADDR  = (state_q == StRdReq) ? AW'({ch_q[2:0], 2'b00}) : '0;
    assign M_AXI_ARPROT  = 3'b000;
    assign M_AXI_RREADY  = (state_q == StRdResp);

    assign rsp_valid     = (state_q == StDone);
    assign rsp_data      = (state_q == StDone) ? rdata_q : '0;
    assign rsp_err       = (state_q == StDone) & err_q;

endmodule
